// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: skid-register FSM encoding and the NOP instruction word.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages; presents a NOP entry when empty
// and counts back-pressured cycles.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*DW-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [CW-1:0]     stall_cnt
);

  localparam int EW = NCH * DW;
  localparam logic [EW-1:0] NOP_ENTRY = EW'(NOP_INSN);

  skid_state_e   state_q, state_d;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          in_fire, out_fire;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Handshake flags come from state alone so no ready/valid path crosses the stage.
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    if (out_valid && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);

    // Every path into EMPTY clears main, which keeps out_data at NOP while idle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_ENTRY;
      skid_d  = NOP_ENTRY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_ENTRY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_ENTRY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_ENTRY;
          skid_d  = NOP_ENTRY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_ENTRY;
      skid_q      <= NOP_ENTRY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table plus a queue model of the two-entry buffer.
module tb_pipe_skid_reg;
  localparam int DW   = 32;
  localparam int NCH  = 4;
  localparam int CW   = 3;
  localparam int EW   = DW * NCH;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [EW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        r, iv, fl, ordy;
    logic [31:0] v;
    logic        eov, eir;
    logic [31:0] ed;
    int          ecnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  logic [31:0] emitted[$];
  int          mcnt = 0;

  pipe_skid_reg #(.DW(DW), .NCH(NCH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic [31:0] v);
    return {v ^ 32'hC000_0000, v ^ 32'hB000_0000, v ^ 32'hA000_0000, v};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, iv, input logic [31:0] v, input logic fl, ordy,
                     input logic eov, eir, input logic [31:0] ed, input int ecnt);
    vec_t t;
    t.r = r; t.iv = iv; t.v = v; t.fl = fl; t.ordy = ordy;
    t.eov = eov; t.eir = eir; t.ed = ed; t.ecnt = ecnt;
    tbl.push_back(t);
  endtask

  // One clock: drive inputs, advance the queue model at the edge, compare just after it.
  task automatic step(input logic r, iv, input logic [31:0] v, input logic fl, ordy);
    logic m_ov, m_ir;
    reset = r; in_valid = iv; in_data = mk(v); flush = fl; out_ready = ordy;
    m_ov = (sb.size() > 0);
    m_ir = (sb.size() < 2);
    if (!r && !fl && out_valid === 1'b1 && ordy) emitted.push_back(out_data[31:0]);
    @(posedge clk);
    if (r) begin
      sb.delete();
      mcnt = 0;
    end else begin
      if (m_ov && !ordy && mcnt < CMAX) mcnt++;
      if (fl) sb.delete();
      else begin
        if (m_ov && ordy) void'(sb.pop_front());
        if (iv && m_ir) sb.push_back(v);
      end
    end
    #1;
    chk("sb_out_valid", EW'(out_valid), EW'(sb.size() > 0));
    chk("sb_in_ready", EW'(in_ready), EW'(sb.size() < 2));
    chk("sb_out_data", out_data, (sb.size() > 0) ? mk(sb[0]) : '0);
    chk("sb_stall_cnt", EW'(stall_cnt), EW'(mcnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    //  r  iv v             fl ordy  ov ir data          cnt
    add(1, 0, 32'h0,        0, 0,    0, 1, 32'h0,        0);
    add(0, 1, 32'h2001_0005,0, 1,    1, 1, 32'h2001_0005,0);
    add(0, 0, 32'h0,        0, 1,    0, 1, 32'h0,        0);
    add(0, 1, 32'h11,       0, 0,    1, 1, 32'h11,       0);
    add(0, 1, 32'h22,       0, 0,    1, 0, 32'h11,       1);
    add(0, 0, 32'h0,        0, 1,    1, 1, 32'h22,       1);
    add(0, 0, 32'h0,        0, 1,    0, 1, 32'h0,        1);
    add(0, 1, 32'h44,       0, 0,    1, 1, 32'h44,       1);
    add(0, 1, 32'h55,       0, 0,    1, 0, 32'h44,       2);
    add(0, 1, 32'h33,       1, 0,    0, 1, 32'h0,        3);
    add(0, 0, 32'h0,        0, 0,    0, 1, 32'h0,        3);
    add(1, 0, 32'h0,        0, 0,    0, 1, 32'h0,        0);
    add(0, 1, 32'h66,       0, 0,    1, 1, 32'h66,       0);
    for (int i = 0; i < 10; i++)
      add(0, 0, 32'h0,      0, 0,    1, 1, 32'h66,       (i + 1 < CMAX) ? i + 1 : CMAX);
    add(0, 1, 32'h77,       0, 0,    1, 0, 32'h66,       CMAX);
    add(1, 1, 32'h88,       1, 0,    0, 1, 32'h0,        0);
    add(0, 0, 32'h0,        0, 1,    0, 1, 32'h0,        0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].v, tbl[i].fl, tbl[i].ordy);
      chk($sformatf("row%0d_out_valid", i), EW'(out_valid), EW'(tbl[i].eov));
      chk($sformatf("row%0d_in_ready", i), EW'(in_ready), EW'(tbl[i].eir));
      chk($sformatf("row%0d_out_data", i), out_data, (tbl[i].ed == 0) ? '0 : mk(tbl[i].ed));
      chk($sformatf("row%0d_stall_cnt", i), EW'(stall_cnt), EW'(tbl[i].ecnt));
    end

    // Sustained streaming at full rate: 1..8 emerge in order, in_ready never drops.
    emitted.delete();
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 32'(i), 0, 1);
      chk($sformatf("stream_in_ready_%0d", i), EW'(in_ready), EW'(1));
    end
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    chk("stream_count", EW'(emitted.size()), EW'(8));
    for (int k = 0; k < emitted.size() && k < 8; k++)
      chk($sformatf("stream_order_%0d", k), EW'(emitted[k]), EW'(k + 1));
    chk("stream_drained_data", out_data, '0);

    // Reset while holding two entries: neither may be emitted afterwards.
    emitted.delete();
    step(0, 1, 32'h91, 0, 0);
    step(0, 1, 32'h92, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    chk("reset_discard_emitted", EW'(emitted.size()), EW'(0));

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++)
      step(0, 1'($urandom_range(0, 1)), $urandom | 32'h1, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DW, 32, width of one pipeline field (IR, PC4, ALU result, DM data, ...).
REQ-002 Parameter NCH, 4, number of fields carried per entry; entry width EW = NCH*DW.
REQ-003 Parameter CW, 16, width of the stall-cycle counter.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream stage presents an entry.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_data  input  EW  upstream entry; field k at bits [k*DW +: DW], field 0 = instruction word.
REQ-009 flush  input  1  discard all held entries (pipeline bubble insertion).
REQ-010 out_valid  output  1  downstream entry present.
REQ-011 out_ready  input  1  downstream stage consumes the entry.
REQ-012 out_data  output  EW  downstream entry.
REQ-013 stall_cnt  output  CW  count of back-pressured cycles.

Function
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 Storage SHALL be two EW registers: main (drives out_data) and skid.
REQ-016 FSM states SHALL be EMPTY, ONE (main full), TWO (main and skid full).
REQ-017 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY; in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, decoded from state only (no combinational path from out_ready or in_valid).
REQ-018 EMPTY: in_fire -> ONE, main <= in_data; otherwise stay.
REQ-019 ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire & !out_fire -> TWO, skid <= in_data; !in_fire & out_fire -> EMPTY, main <= 0; neither -> hold.
REQ-020 TWO: out_fire -> ONE, main <= skid, skid <= 0; otherwise hold both.
REQ-021 out_data SHALL be all-zero whenever out_valid = 0, so an empty stage presents a NOP (instruction word 0).
REQ-022 Entries SHALL leave in acceptance order; no entry dropped or duplicated absent flush/reset.
REQ-023 Latency: an entry accepted into EMPTY appears on out_data the following cycle.
REQ-024 Throughput: one entry per cycle sustained while out_ready = 1.
REQ-025 flush = 1: next state EMPTY, main and skid <= 0, regardless of in_fire/out_fire that cycle; the entry presented on in_data that cycle is discarded.
REQ-026 stall_cnt SHALL increment by 1 each cycle with out_valid & !out_ready, saturating at 2^CW-1; flush does not clear it.

Reset
REQ-027 reset SHALL take priority over flush and all handshakes.
REQ-028 On reset: state EMPTY, main = 0, skid = 0, stall_cnt = 0; hence out_valid = 0, in_ready = 1, out_data = 0 in the following cycle.
REQ-029 Reset asserted mid-operation (state ONE or TWO) SHALL discard all held entries without emitting them.

Structure
REQ-030 FSM state encoding (EMPTY/ONE/TWO) and the NOP constant (32'h0) SHALL live in the shared pipeline package.
REQ-031 Single module; no sub-modules; field slicing SHALL be done by the instantiating stage.

Verification
REQ-032 Reset then in_valid=1, in_data field0=32'h2001_0005, out_ready=1 -> out_valid=1 and field0=32'h2001_0005 one cycle later, in_ready stays 1.
REQ-033 out_ready=0, push A=0x11, B=0x22 on consecutive cycles -> state TWO, in_ready=0, out_data=A; raise out_ready -> A, then B, in consecutive cycles, then out_valid=0, out_data=0.
REQ-034 Stream 8 entries 1..8 with out_ready=1 every cycle -> 8 consecutive output cycles, values 1..8 in order, in_ready never drops.
REQ-035 State TWO, flush=1 with in_valid=1 carrying 0x33 -> next cycle out_valid=0, out_data=0, in_ready=1; 0x33 never emitted.
REQ-036 CW=3, hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt reads 1..7 then stays 7.
REQ-037 State TWO, reset=1 and flush=1 together -> next cycle EMPTY, stall_cnt=0, out_data=0.
